// File: rtl/axi_lite_reg_sweeper.sv
// AXI4-Lite register sweeper: writes LFSR patterns over a register window,
// reads them back and reports pass/fail with a saturating error count.
module axi_lite_reg_sweeper #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                NUM_REGS  = 4,
  parameter logic [31:0]       SEED      = 32'h0101FFFF
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] M_AXI_AWADDR,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  output logic [31:0]       M_AXI_WDATA,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,
  input  logic [1:0]        M_AXI_BRESP,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY,
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  input  logic [31:0]       M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY
);

  typedef enum logic [2:0] {
    S_IDLE, S_WA, S_WB, S_RA, S_RD, S_NEXT, S_FIN
  } state_t;

  localparam logic [7:0]  LAST_IDX = 8'(NUM_REGS - 1);
  localparam logic [31:0] POLY     = 32'h80200003;

  state_t            state_q, state_d;
  logic [7:0]        idx_q, idx_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        mode_q, mode_d;
  logic              aw_ok_q, aw_ok_d;
  logic              w_ok_q, w_ok_d;
  logic [15:0]       err_q, err_d;
  logic              pass_q, pass_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign M_AXI_AWVALID = (state_q == S_WA) && !aw_ok_q;
  assign M_AXI_WVALID  = (state_q == S_WA) && !w_ok_q;
  assign M_AXI_BREADY  = (state_q == S_WB);
  assign M_AXI_ARVALID = (state_q == S_RA);
  assign M_AXI_RREADY  = (state_q == S_RD);
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_WDATA   = lfsr_q;

  assign busy      = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done      = (state_q == S_FIN);
  assign pass      = pass_q;
  assign err_count = err_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    lfsr_d  = lfsr_q;
    addr_d  = addr_q;
    mode_d  = mode_q;
    aw_ok_d = aw_ok_q;
    w_ok_d  = w_ok_q;
    err_d   = err_q;
    pass_d  = pass_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d   = '0;
          pass_d  = 1'b0;
          idx_d   = '0;
          lfsr_d  = SEED;
          addr_d  = BASE_ADDR;
          mode_d  = mode;
          aw_ok_d = 1'b0;
          w_ok_d  = 1'b0;
          state_d = (mode == 2'd2) ? S_RA : S_WA;
        end
      end
      S_WA: begin
        if (M_AXI_AWVALID && M_AXI_AWREADY) aw_ok_d = 1'b1;
        if (M_AXI_WVALID && M_AXI_WREADY) w_ok_d = 1'b1;
        // each channel completes independently; move on once both have
        if ((aw_ok_q || M_AXI_AWREADY) && (w_ok_q || M_AXI_WREADY)) begin
          aw_ok_d = 1'b0;
          w_ok_d  = 1'b0;
          state_d = S_WB;
        end
      end
      S_WB: begin
        if (M_AXI_BVALID) begin
          if (M_AXI_BRESP != 2'b00) err_d = sat_inc(err_q);
          state_d = (mode_q == 2'd1) ? S_NEXT : S_RA;
        end
      end
      S_RA: begin
        if (M_AXI_ARREADY) state_d = S_RD;
      end
      S_RD: begin
        if (M_AXI_RVALID) begin
          if ((M_AXI_RDATA != lfsr_q) || (M_AXI_RRESP != 2'b00))
            err_d = sat_inc(err_q);
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? POLY : 32'h0);
        idx_d  = idx_q + 8'd1;
        addr_d = addr_q + ADDR_W'(4);
        if (idx_q == LAST_IDX) begin
          pass_d  = (err_q == 16'd0);
          state_d = S_FIN;
        end else begin
          state_d = (mode_q == 2'd2) ? S_RA : S_WA;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      lfsr_q  <= '0;
      addr_q  <= '0;
      mode_q  <= '0;
      aw_ok_q <= 1'b0;
      w_ok_q  <= 1'b0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lfsr_q  <= lfsr_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      aw_ok_q <= aw_ok_d;
      w_ok_q  <= w_ok_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_sweeper.sv
// Bench for axi_lite_reg_sweeper: memory slave with fault knobs,
// vector table of sweep runs plus a mid-run reset sequence.
module tb_axi_lite_reg_sweeper;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR, M_AXI_RDATA;
  logic        M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP, M_AXI_RRESP;
  logic        M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
  logic        M_AXI_RVALID, M_AXI_RREADY;

  always #5 ACLK = ~ACLK;

  axi_lite_reg_sweeper #(
    .ADDR_W(32), .BASE_ADDR(32'h0), .NUM_REGS(4), .SEED(32'h0101FFFF)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET), .start(start), .mode(mode),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
    .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
  );

  // slave knobs
  int          aw_delay = 0;
  bit          bresp_err = 1'b0;
  bit          cor_en = 1'b0;
  int          cor_word = 0;
  logic [31:0] cor_mask = 32'h0;
  bit          mem_clear = 1'b0;

  logic [31:0] mem [64];
  logic        aw_got = 1'b0, w_got = 1'b0, bvalid = 1'b0, rvalid = 1'b0;
  logic [5:0]  aw_idx = '0;
  logic [31:0] w_dat = '0, rdata = '0;
  int          aw_cnt = 0;

  assign M_AXI_AWREADY = (aw_delay == 0) || (aw_cnt >= aw_delay - 1);
  assign M_AXI_WREADY  = 1'b1;
  assign M_AXI_ARREADY = 1'b1;
  assign M_AXI_BVALID  = bvalid;
  assign M_AXI_BRESP   = bresp_err ? 2'b10 : 2'b00;
  assign M_AXI_RVALID  = rvalid;
  assign M_AXI_RDATA   = rdata;
  assign M_AXI_RRESP   = 2'b00;

  always @(posedge ACLK) begin
    if (ARESET) begin
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      bvalid <= 1'b0;
      rvalid <= 1'b0;
      aw_cnt <= 0;
    end else begin
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        aw_got <= 1'b1;
        aw_idx <= M_AXI_AWADDR[7:2];
        aw_cnt <= 0;
      end else if (M_AXI_AWVALID) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        w_got <= 1'b1;
        w_dat <= M_AXI_WDATA;
      end
      if (aw_got && w_got) begin
        mem[aw_idx] <= w_dat;
        bvalid <= 1'b1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if (bvalid && M_AXI_BREADY) bvalid <= 1'b0;
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        rvalid <= 1'b1;
        rdata  <= mem[M_AXI_ARADDR[7:2]] ^ (cor_mask &
                  {32{cor_en && (M_AXI_ARADDR[7:2] == cor_word[5:0])}});
      end
      if (rvalid && M_AXI_RREADY) rvalid <= 1'b0;
    end
    if (mem_clear)
      for (int i = 0; i < 64; i++) mem[i] <= '0;
  end

  // hand-computed LFSR sequence from 0x0101FFFF, poly 0x80200003
  logic [31:0] pat [4];
  initial begin
    pat[0] = 32'h0101FFFF;
    pat[1] = 32'h80A0FFFC;
    pat[2] = 32'h40507FFE;
    pat[3] = 32'h20283FFF;
  end

  // protocol monitor, sampled on the falling edge
  int          aw_hi = 0, w_hi = 0, aw_hs = 0, w_hs = 0, ar_hs = 0;
  int          done_cnt = 0, proto_err = 0;
  logic        aw_pend = 1'b0, w_pend = 1'b0;
  logic [31:0] aw_prev = '0, w_prev = '0;

  always @(negedge ACLK) begin
    if (start && !busy) begin
      aw_hi = 0; w_hi = 0; aw_hs = 0; w_hs = 0; ar_hs = 0;
      done_cnt = 0; proto_err = 0;
    end else begin
      if (M_AXI_AWVALID) aw_hi++;
      if (M_AXI_WVALID) w_hi++;
      if (done) done_cnt++;
      if (aw_pend && (!M_AXI_AWVALID || M_AXI_AWADDR != aw_prev))
        proto_err++;
      if (w_pend && (!M_AXI_WVALID || M_AXI_WDATA != w_prev))
        proto_err++;
      if (M_AXI_AWVALID && M_AXI_AWREADY) begin
        if (M_AXI_AWADDR != 32'(aw_hs * 4)) proto_err++;
        aw_hs++;
      end
      if (M_AXI_WVALID && M_AXI_WREADY) begin
        if (w_hs < 4 && M_AXI_WDATA != pat[w_hs]) proto_err++;
        w_hs++;
      end
      if (M_AXI_ARVALID && M_AXI_ARREADY) begin
        if (M_AXI_ARADDR != 32'(ar_hs * 4)) proto_err++;
        ar_hs++;
      end
    end
    aw_pend = M_AXI_AWVALID && !M_AXI_AWREADY;
    w_pend  = M_AXI_WVALID && !M_AXI_WREADY;
    aw_prev = M_AXI_AWADDR;
    w_prev  = M_AXI_WDATA;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic run(input string name, input logic [1:0] m, input int poke,
                     output bit got_done, output logic p,
                     output logic [15:0] e);
    got_done = 1'b0;
    p = 1'b0;
    e = '0;
    mode = m;
    @(posedge ACLK); #1 start = 1'b1;
    @(posedge ACLK); #1 start = 1'b0;
    @(negedge ACLK);
    chk($sformatf("%s busy_rise", name), busy, 1);
    for (int c = 0; c < 400 && !got_done; c++) begin
      @(negedge ACLK);
      start = (c == poke);
      if (done) begin
        got_done = 1'b1;
        p = pass;
        e = err_count;
      end
    end
    start = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [1:0]  mode;
    bit          clear;
    bit          bresp;
    bit          cor;
    int          cor_word;
    logic [31:0] cor_mask;
    int          awd;
    bit          exp_pass;
    int          exp_err;
    int          exp_aw_hi;
    int          exp_w_hi;
    int          exp_ar;
  } vec_t;

  vec_t vecs [9];

  initial begin
    bit          gd;
    logic        p;
    logic [15:0] e;
    bit          found;

    vecs[0] = '{"mode0_clean",    2'd0, 1, 0, 0, 0, 32'h0,   0, 1, 0, 4,  4, 4};
    vecs[1] = '{"rd_bit0_reg1",   2'd0, 0, 0, 1, 1, 32'h1,   0, 0, 1, 4,  4, 4};
    vecs[2] = '{"awready_dly5",   2'd0, 0, 0, 0, 0, 32'h0,   5, 1, 0, 20, 4, 4};
    vecs[3] = '{"bresp_slverr",   2'd0, 0, 1, 0, 0, 32'h0,   0, 0, 4, 4,  4, 4};
    vecs[4] = '{"mode3_clean",    2'd3, 0, 0, 0, 0, 32'h0,   0, 1, 0, 4,  4, 4};
    vecs[5] = '{"mode2_cleared",  2'd2, 1, 0, 0, 0, 32'h0,   0, 0, 4, 0,  0, 4};
    vecs[6] = '{"mode1_write",    2'd1, 0, 0, 0, 0, 32'h0,   0, 1, 0, 4,  4, 0};
    vecs[7] = '{"mode2_verify",   2'd2, 0, 0, 0, 0, 32'h0,   0, 1, 0, 0,  0, 4};
    vecs[8] = '{"mode2_corrupt8", 2'd2, 0, 0, 1, 2, 32'h100, 0, 0, 1, 0,  0, 4};

    repeat (3) @(negedge ACLK);
    chk("reset_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                         M_AXI_ARVALID, M_AXI_RREADY}, 0);
    chk("reset_status", {busy, done, pass}, 0);
    chk("reset_err", err_count, 0);
    chk("reset_addr_data", {M_AXI_AWADDR, M_AXI_WDATA}, 0);
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("idle_busy", busy, 0);

    foreach (vecs[i]) begin
      aw_delay  = vecs[i].awd;
      bresp_err = vecs[i].bresp;
      cor_en    = vecs[i].cor;
      cor_word  = vecs[i].cor_word;
      cor_mask  = vecs[i].cor_mask;
      if (vecs[i].clear) begin
        mem_clear = 1'b1;
        @(negedge ACLK);
        mem_clear = 1'b0;
      end
      run(vecs[i].name, vecs[i].mode, -1, gd, p, e);
      chk($sformatf("%s done", vecs[i].name), gd, 1);
      chk($sformatf("%s pass", vecs[i].name), p, vecs[i].exp_pass);
      chk($sformatf("%s err_count", vecs[i].name), e, vecs[i].exp_err);
      repeat (3) @(negedge ACLK);
      chk($sformatf("%s done_pulses", vecs[i].name), done_cnt, 1);
      chk($sformatf("%s busy_after", vecs[i].name), busy, 0);
      chk($sformatf("%s pass_held", vecs[i].name), pass, vecs[i].exp_pass);
      chk($sformatf("%s awvalid_cycles", vecs[i].name), aw_hi,
          vecs[i].exp_aw_hi);
      chk($sformatf("%s wvalid_cycles", vecs[i].name), w_hi,
          vecs[i].exp_w_hi);
      chk($sformatf("%s reads", vecs[i].name), ar_hs, vecs[i].exp_ar);
      chk($sformatf("%s protocol", vecs[i].name), proto_err, 0);
      if (i == 0) begin
        for (int k = 0; k < 4; k++)
          chk($sformatf("mem_word%0d", k), mem[k], pat[k]);
        chk("mem_word4_untouched", mem[4], 0);
      end
    end
    aw_delay  = 0;
    bresp_err = 1'b0;

    // reset during the RD beat of register 2
    cor_en   = 1'b1;
    cor_word = 0;
    cor_mask = 32'h1;
    mode     = 2'd0;
    @(posedge ACLK); #1 start = 1'b1;
    @(posedge ACLK); #1 start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge ACLK);
      if (M_AXI_RREADY && ar_hs == 3) found = 1'b1;
    end
    chk("midrst reached_rd2", found, 1);
    chk("midrst err_before", err_count, 1);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    chk("midrst valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                          M_AXI_ARVALID, M_AXI_RREADY}, 0);
    chk("midrst status", {busy, done, pass}, 0);
    chk("midrst err", err_count, 0);
    chk("midrst addr_data", {M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA}, 0);
    repeat (10) @(negedge ACLK);
    chk("midrst no_done", done_cnt, 0);
    chk("midrst idle", busy, 0);
    cor_en = 1'b0;

    // clean run with a start pulse while busy
    run("after_rst", 2'd0, 6, gd, p, e);
    chk("after_rst done", gd, 1);
    chk("after_rst pass", p, 1);
    chk("after_rst err_count", e, 0);
    repeat (3) @(negedge ACLK);
    chk("after_rst done_pulses", done_cnt, 1);
    chk("after_rst awvalid_cycles", aw_hi, 4);
    chk("after_rst protocol", proto_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
